mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single external memory port between instruction fetch (I) and the
//  memory stage (D). Accepts one outstanding single-beat request per requester,
//  grants one at a time, registers it onto the downstream port, and returns data_ok
//  plus data to the winner. Sits between the core (fetch, memu) and the memory/cache.
// PARAMETERS
//  STARVE_LIMIT  4   back-to-back D grants while I waits before I is forced to win (>=1)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  ireq_valid     in   1   fetch request pending; held until ireq_data_ok
//  ireq_addr      in   64  fetch address
//  iresp_data_ok  out  1   one-cycle pulse: fetch complete
//  iresp_data     out  64  fetch read data, valid with iresp_data_ok
//  dreq_valid     in   1   data request pending; held until dresp_data_ok
//  dreq_addr      in   64  data address
//  dreq_size      in   3   log2 bytes (0..3)
//  dreq_strobe    in   8   byte write enables; 0 = read
//  dreq_data      in   64  write data, already lane-aligned
//  dresp_data_ok  out  1   one-cycle pulse: data access complete
//  dresp_data     out  64  read data (raw 64-bit word), valid with dresp_data_ok
//  oreq_valid     out  1   downstream request
//  oreq_is_write  out  1   1 when latched strobe != 0
//  oreq_addr      out  64  downstream address
//  oreq_size      out  3   downstream size (I requests always 3'd2)
//  oreq_strobe    out  8   downstream strobe (I requests always 0)
//  oreq_data      out  64  downstream write data (I requests 0)
//  oresp_ready    in   1   downstream beat valid
//  oresp_last     in   1   final beat; completion = oresp_ready && oresp_last
//  oresp_data     in   64  downstream read data
// BEHAVIOUR
//  Reset: state IDLE, starve_cnt 0, every output 0 (registered request fields cleared).
//  Reset mid-transaction abandons it; no data_ok is issued; downstream must drop it.
//  FSM: IDLE -> BUSY_I | BUSY_D -> RESP -> IDLE.
//  IDLE: no request -> stay. Grant rule at the clock edge:
//   - only one valid -> grant it;
//   - both valid -> D wins unless starve_cnt == STARVE_LIMIT, then I wins.
//   Winner's fields latched into oreq_* regs; oreq_valid=1 from the next cycle (1-cycle grant latency).
//  starve_cnt: +1 on each D grant with ireq_valid high (saturates at STARVE_LIMIT);
//   cleared on any I grant or on a D grant with ireq_valid low.
//  BUSY_x: oreq_* held stable, oreq_valid=1. Requester inputs are ignored (no re-sampling).
//   oresp_ready && !oresp_last: ignored. oresp_ready && oresp_last: latch oresp_data,
//   oreq_valid<=0, -> RESP. Completion in the first BUSY cycle is legal.
//  RESP (exactly one cycle): winner's *_data_ok=1, *_data=latched data; loser's data_ok=0.
//   Requester drops valid at the edge that samples data_ok, so IDLE never re-grants a finished
//   request. *_data holds last value outside RESP; only data_ok qualifies it.
//  Minimum turnaround: request in cycle 0, oreq_valid cycle 1, completion cycle 1,
//   data_ok cycle 2, next grant possible at edge ending cycle 3.
//  No address/size checks: misaligned or out-of-range accesses pass through unchanged.
//  iresp_data_ok and dresp_data_ok are never high together; at most one oreq in flight.
// TESTING
//  1 Lone fetch addr 0x8000_0000, memory returns 0x0000_0013_0000_0093 after 2 cycles ->
//    oreq_valid cycle 1, size 2, strobe 0; iresp_data_ok one pulse with that data.
//  2 Store addr 0x8000_1004 strobe 0xF0 data 0xDEAD_BEEF_0000_0000 -> oreq_is_write=1, same
//    fields on port; dresp_data_ok one pulse; iresp_data_ok stays 0.
//  3 I and D valid same cycle, starve_cnt 0 -> D granted first, I granted next IDLE.
//  4 D re-requests every IDLE while I held valid, STARVE_LIMIT=4 -> 4 D grants then I,
//    starve_cnt back to 0.
//  5 rst asserted in BUSY_D before oresp_last -> all outputs 0 immediately (async), no data_ok,
//    clean fresh grant after release.
//  6 oresp_ready=1 with oresp_last=0 for 3 cycles then last -> single data_ok, last-beat data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Shares one single-beat memory port between fetch (I) and data (D).
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq_valid_i,
    input  logic [63:0] ireq_addr_i,
    output logic        iresp_data_ok_o,
    output logic [63:0] iresp_data_o,
    input  logic        dreq_valid_i,
    input  logic [63:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [7:0]  dreq_strobe_i,
    input  logic [63:0] dreq_data_i,
    output logic        dresp_data_ok_o,
    output logic [63:0] dresp_data_o,
    output logic        oreq_valid_o,
    output logic        oreq_is_write_o,
    output logic [63:0] oreq_addr_o,
    output logic [2:0]  oreq_size_o,
    output logic [7:0]  oreq_strobe_o,
    output logic [63:0] oreq_data_o,
    input  logic        oresp_ready_i,
    input  logic        oresp_last_i,
    input  logic [63:0] oresp_data_i
);

    localparam int                 c_CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] starve_q, starve_d;
    logic               oreq_valid_q, oreq_is_write_q;
    logic [63:0]        oreq_addr_q, oreq_data_q;
    logic [2:0]         oreq_size_q;
    logic [7:0]         oreq_strobe_q;
    logic               iresp_ok_q, dresp_ok_q;
    logic [63:0]        iresp_data_q, dresp_data_q;

    logic w_idle, w_grant_d, w_grant_i, w_done;

    // D normally wins a tie; I wins once D has taken STARVE_LIMIT grants in a row over it.
    assign w_idle    = (state_q == c_IDLE);
    assign w_grant_d = w_idle && dreq_valid_i && !(ireq_valid_i && (starve_q == c_STARVE_MAX));
    assign w_grant_i = w_idle && ireq_valid_i && !w_grant_d;
    assign w_done    = ((state_q == c_BUSY_I) || (state_q == c_BUSY_D)) && oresp_ready_i && oresp_last_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant_d) begin
                    state_d = c_BUSY_D;
                end else if (w_grant_i) begin
                    state_d = c_BUSY_I;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (w_done) begin
                    state_d = c_RESP;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (w_grant_i) begin
            starve_d = '0;
        end else if (w_grant_d) begin
            if (!ireq_valid_i) begin
                starve_d = '0;
            end else if (starve_q != c_STARVE_MAX) begin
                starve_d = starve_q + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= c_IDLE;
            starve_q        <= '0;
            oreq_valid_q    <= 1'b0;
            oreq_is_write_q <= 1'b0;
            oreq_addr_q     <= '0;
            oreq_size_q     <= '0;
            oreq_strobe_q   <= '0;
            oreq_data_q     <= '0;
            iresp_ok_q      <= 1'b0;
            dresp_ok_q      <= 1'b0;
            iresp_data_q    <= '0;
            dresp_data_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (w_grant_d) begin
                oreq_valid_q    <= 1'b1;
                oreq_is_write_q <= |dreq_strobe_i;
                oreq_addr_q     <= dreq_addr_i;
                oreq_size_q     <= dreq_size_i;
                oreq_strobe_q   <= dreq_strobe_i;
                oreq_data_q     <= dreq_data_i;
            end else if (w_grant_i) begin
                oreq_valid_q    <= 1'b1;
                oreq_is_write_q <= 1'b0;
                oreq_addr_q     <= ireq_addr_i;
                oreq_size_q     <= 3'd2;
                oreq_strobe_q   <= 8'd0;
                oreq_data_q     <= 64'd0;
            end
            if (w_done) begin
                oreq_valid_q <= 1'b0;
                if (state_q == c_BUSY_D) begin
                    dresp_data_q <= oresp_data_i;
                    dresp_ok_q   <= 1'b1;
                end else begin
                    iresp_data_q <= oresp_data_i;
                    iresp_ok_q   <= 1'b1;
                end
            end
            if (state_q == c_RESP) begin
                iresp_ok_q <= 1'b0;
                dresp_ok_q <= 1'b0;
            end
        end
    end

    assign oreq_valid_o    = oreq_valid_q;
    assign oreq_is_write_o = oreq_is_write_q;
    assign oreq_addr_o     = oreq_addr_q;
    assign oreq_size_o     = oreq_size_q;
    assign oreq_strobe_o   = oreq_strobe_q;
    assign oreq_data_o     = oreq_data_q;
    assign iresp_data_ok_o = iresp_ok_q;
    assign iresp_data_o    = iresp_data_q;
    assign dresp_data_ok_o = dresp_ok_q;
    assign dresp_data_o    = dresp_data_q;

endmodule
`default_nettype wire
